// File: rtl/alu_mux.sv
// Single-cycle registered 32-bit ALU with twelve priority-ordered enable strobes.
// Define ALU_WORD_OPS_EN to make subw_en/sraw_en active; otherwise they are ignored.
module alu_mux_sel #(
  parameter int XLEN = 32
) (
  input  logic            en,
  input  logic            taken_in,
  input  logic [XLEN-1:0] res,
  output logic            gnt,
  output logic            taken_out,
  output logic [XLEN-1:0] res_gated
);
  // A lower-priority strobe (even X) is masked once any higher one has claimed the cycle.
  assign gnt       = en & ~taken_in;
  assign taken_out = taken_in | en;
  assign res_gated = res & {XLEN{gnt}};
endmodule

module alu_mux #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sub_en,
  input  logic            sra_en,
  input  logic            subw_en,
  input  logic            sraw_en,
  input  logic            add_en,
  input  logic            sll_en,
  input  logic            slt_en,
  input  logic            sltu_en,
  input  logic            xor_en,
  input  logic            srl_en,
  input  logic            or_en,
  input  logic            and_en,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_valid
);
  localparam int NOPS = 12;

  typedef struct packed {
    logic [NOPS-1:0] en;  // bit 0 is highest priority
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } alu_req_t;

`ifdef ALU_WORD_OPS_EN
  localparam logic [NOPS-1:0] OP_MASK = 12'hFFF;
`else
  localparam logic [NOPS-1:0] OP_MASK = 12'hFF3;
`endif

  alu_req_t                   req;
  logic [4:0]                 shamt;
  logic [XLEN-1:0]            sra_res;
  logic                       lt_s, lt_u;
  logic [NOPS-1:0]            act, gnt;
  logic [NOPS:0]              taken;
  logic [NOPS-1:0][XLEN-1:0]  res, res_gated;
  logic [XLEN-1:0]            rd_next;
  logic                       any_gnt;

  assign req.en = {and_en, or_en, srl_en, xor_en, sltu_en, slt_en,
                   sll_en, add_en, sraw_en, subw_en, sra_en, sub_en};
  assign req.a  = rs1_data;
  assign req.b  = rs2_data;

  assign shamt   = req.b[4:0];
  assign sra_res = $signed(req.a) >>> shamt;
  assign lt_s    = $signed(req.a) < $signed(req.b);
  assign lt_u    = req.a < req.b;

  assign res[0]  = req.a - req.b;
  assign res[1]  = sra_res;
  assign res[2]  = req.a - req.b;
  assign res[3]  = sra_res;
  assign res[4]  = req.a + req.b;
  assign res[5]  = req.a << shamt;
  assign res[6]  = {{(XLEN-1){1'b0}}, lt_s};
  assign res[7]  = {{(XLEN-1){1'b0}}, lt_u};
  assign res[8]  = req.a ^ req.b;
  assign res[9]  = req.a >> shamt;
  assign res[10] = req.a | req.b;
  assign res[11] = req.a & req.b;

  assign act      = req.en & OP_MASK;
  assign taken[0] = 1'b0;

  for (genvar i = 0; i < NOPS; i++) begin : g_sel
    alu_mux_sel #(.XLEN(XLEN)) u_sel (
      .en        (act[i]),
      .taken_in  (taken[i]),
      .res       (res[i]),
      .gnt       (gnt[i]),
      .taken_out (taken[i+1]),
      .res_gated (res_gated[i])
    );
  end

  // Grant is one-hot, so an OR-reduce of the gated results is the mux.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NOPS; i++) rd_next = rd_next | res_gated[i];
  end

  assign any_gnt = taken[NOPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= any_gnt;
      if (any_gnt) rd_data <= rd_next;
    end
  end
endmodule

// File: tb/tb_alu_mux.sv
// Scoreboarded bench for alu_mux: directed plan vectors, async reset cases, random traffic.
module tb_alu_mux;
  localparam int SUB = 0, SRA = 1, SUBW = 2, SRAW = 3, ADD = 4, SLL = 5,
                 SLT = 6, SLTU = 7, XOR = 8, SRL = 9, OR = 10, AND = 11;
`ifdef ALU_WORD_OPS_EN
  localparam bit WORD = 1'b1;
`else
  localparam bit WORD = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [11:0] en = '0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] rd_data;
  logic        rd_valid;

  typedef struct {
    string       nm;
    logic [32:0] exp;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_d = '0;

  always #5 clk = ~clk;

  alu_mux #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .sub_en(en[SUB]), .sra_en(en[SRA]), .subw_en(en[SUBW]), .sraw_en(en[SRAW]),
    .add_en(en[ADD]), .sll_en(en[SLL]), .slt_en(en[SLT]), .sltu_en(en[SLTU]),
    .xor_en(en[XOR]), .srl_en(en[SRL]), .or_en(en[OR]), .and_en(en[AND]),
    .rs1_data(a), .rs2_data(b), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // Reference: walk the enables in priority order, apply the op's arithmetic rule.
  function automatic logic [32:0] model(input logic [11:0] e, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] prev);
    int unsigned   sh;
    longint unsigned p;
    logic [31:0]   r;
    sh = int'(y % 32);
    for (int i = 0; i < 12; i++) begin
      if (!e[i]) continue;
      if ((i == SUBW || i == SRAW) && !WORD) continue;
      case (i)
        SUB, SUBW: r = x - y;
        SRA, SRAW: begin
          r = x;
          for (int k = 0; k < 32; k++) if (k < sh) r = {x[31], r[31:1]};
        end
        ADD:  r = x + y;
        SLL:  begin p = longint'(x) * (64'd1 << sh); r = p[31:0]; end
        SLT:  r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
        SLTU: r = (x < y) ? 32'd1 : 32'd0;
        XOR:  r = x ^ y;
        SRL:  r = x / (32'd1 << sh);
        OR:   r = x | y;
        default: r = x & y;
      endcase
      return {1'b1, r};
    end
    return {1'b0, prev};
  endfunction

  task automatic cyc(input string nm, input logic [11:0] e, input logic [31:0] x,
                     input logic [31:0] y);
    exp_t t;
    @(negedge clk);
    en = e; a = x; b = y;
    t.nm  = nm;
    t.exp = model(e, x, y, last_d);
    last_d = t.exp[31:0];
    q.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got valid=%0b data=%08h, want valid=%0b data=%08h",
               nm, act[32], act[31:0], exp[32], exp[31:0]);
    end
  endtask

  initial begin : monitor
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && q.size() > 0) begin
        t = q.pop_front();
        chk(t.nm, {rd_valid, rd_data}, t.exp);
      end
    end
  end

  function automatic logic [11:0] bitm(input int i);
    logic [11:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    logic [11:0] e;
    int          bound;
    #1;
    chk("reset_async", {rd_valid, rd_data}, 33'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", {rd_valid, rd_data}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    cyc("add_5_6", bitm(ADD), 32'd5, 32'd6);
    cyc("or_2_3", bitm(OR), 32'd2, 32'd3);
    cyc("and_1_2", bitm(AND), 32'd1, 32'd2);
    cyc("xor_f_a", bitm(XOR), 32'hF, 32'hA);
    cyc("slt_pos", bitm(SLT), 32'h0000_F001, 32'h0000_F002);
    cyc("slt_neg", bitm(SLT), 32'hF000_0002, 32'hF000_0001);
    cyc("slt_m1_1", bitm(SLT), 32'hFFFF_FFFF, 32'd1);
    cyc("sltu_m1_1", bitm(SLTU), 32'hFFFF_FFFF, 32'd1);
    cyc("sra_4", bitm(SRA), 32'h8000_0000, 32'd4);
    cyc("srl_4", bitm(SRL), 32'h8000_0000, 32'd4);
    cyc("sll_shamt5", bitm(SLL), 32'd1, 32'h25);
    cyc("sub_0_1", bitm(SUB), 32'd0, 32'd1);
    cyc("prio_sub", bitm(ADD) | bitm(OR) | bitm(SUB), 32'hF, 32'h0);
    cyc("idle_hold", 12'h0, 32'h1234, 32'h5678);
    cyc("subw_f_1", bitm(SUBW), 32'hF, 32'h1);
    cyc("sraw_lt_add", bitm(SRAW) | bitm(ADD), 32'h8000_0000, 32'd1);
    cyc("held_add_1", bitm(ADD), 32'd100, 32'd1);
    cyc("held_add_2", bitm(ADD), 32'hFFFF_FFFF, 32'd2);

    // Reset landing while an add is in flight must discard it.
    @(negedge clk);
    mon_en = 1'b0;
    en = bitm(ADD); a = 32'd7; b = 32'd8;
    #2 rst_n = 1'b0;
    #1 chk("reset_midop", {rd_valid, rd_data}, 33'h0);
    @(posedge clk);
    #1 chk("reset_midop_held", {rd_valid, rd_data}, 33'h0);
    @(negedge clk);
    q.delete();
    en = '0;
    rst_n = 1'b1;
    last_d = '0;
    mon_en = 1'b1;
    cyc("post_reset_idle", 12'h0, 32'd3, 32'd4);
    cyc("post_reset_add", bitm(ADD), 32'd3, 32'd4);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       e = '0;
        1, 2:    e = bitm(SUBW) & 12'($urandom_range(0, 1) ? 12'hFFF : 12'h0) | bitm(SRAW);
        3, 4, 5, 6: e = bitm($urandom_range(0, 11));
        default: e = 12'($urandom);
      endcase
      cyc("random", e, rand_op(), rand_op());
    end

    @(negedge clk);
    en = '0;
    bound = 0;
    while (q.size() > 0 && bound < 10) begin
      @(negedge clk);
      bound++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_mux.md
# alu_mux

Single-cycle registered integer ALU for the 32-bit execute stage. It selects one of twelve operations through individual enable strobes, computes the result from two register-file operands, and registers it for the writeback path. A fixed priority resolves simultaneous enables, so decode glitches never produce a blended result.

## Interface
Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sub_en  in  1  rd = rs1 − rs2.
- sra_en  in  1  arithmetic right shift.
- subw_en  in  1  word subtract (see Configuration).
- sraw_en  in  1  word arithmetic right shift (see Configuration).
- add_en  in  1  rd = rs1 + rs2.
- sll_en  in  1  logical left shift.
- slt_en  in  1  signed less-than.
- sltu_en  in  1  unsigned less-than.
- xor_en  in  1  bitwise XOR.
- srl_en  in  1  logical right shift.
- or_en  in  1  bitwise OR.
- and_en  in  1  bitwise AND.
- rs1_data  in  32  operand A.
- rs2_data  in  32  operand B.
- rd_data  out  32  registered result.
- rd_valid  out  1  high for the cycle in which rd_data holds a result computed from an enabled operation.

## Operation
- Priority, highest first, follows port order: sub, sra, subw, sraw, add, sll, slt, sltu, xor, srl, or, and. Only the highest-priority asserted enable takes effect.
- Add and sub wrap modulo 2^32. Carry and overflow are discarded.
- Shift amount is rs2_data[4:0]. rs2_data[31:5] is ignored.
  - sll and srl fill with zeros.
  - sra fills with rs1_data[31].
- slt compares both operands as two's complement. sltu compares them as unsigned. In both cases rd = {31'b0, less}.
- Logical operations are bitwise over all 32 bits.
- When no enable is asserted (or only a disabled word op is asserted):
  - rd_data holds its previous value.
  - rd_valid is driven 0.
- X or Z on an unselected operation has no effect on rd_data.

## Timing
- Latency is 1 cycle. Enables and operands are sampled at rising edge N, and rd_data/rd_valid reflect them after edge N.
- Throughput is one operation per cycle, with no handshake and no stall.
- Reset, asynchronous on the falling edge of rst_n:
  - rd_data = 32'h0 and rd_valid = 0 immediately.
  - Both stay there while rst_n is low.
  - The first result appears one edge after an enabled cycle following reset release.
- Enable held high across cycles: a new result is computed every cycle from the current operands.
- Reset asserted mid-operation discards the in-flight result.

## Configuration
- ALU_WORD_OPS_EN defined:
  - subw_en behaves as a 32-bit subtract (identical result to sub).
  - sraw_en behaves as sra using shamt rs2_data[4:0].
  - Both remain in the priority order.
- ALU_WORD_OPS_EN undefined:
  - subw_en and sraw_en are ignored and drop out of the priority order.
  - A cycle with only those enables asserted is a no-operation cycle: rd_data holds and rd_valid = 0.

## Test plan
- Reset and add: assert rst_n low, expect rd_data = 0 and rd_valid = 0. Release reset, then apply add_en with rs1 = 5, rs2 = 6. After 1 edge, expect rd = 0x0000000B and rd_valid = 1.
- Logic ops, one enable at a time:
  - or, 2 and 3 → 0x3.
  - and, 1 and 2 → 0x0.
  - xor, 0xF and 0xA → 0x5.
- Compares:
  - slt, 0x0000F001 vs 0x0000F002 → 1.
  - slt, 0xF0000002 vs 0xF0000001 → 0.
  - slt, 0xFFFFFFFF vs 1 → 1.
  - sltu, 0xFFFFFFFF vs 1 → 0.
- Shifts and subtract:
  - sra, 0x80000000 by 4 → 0xF8000000.
  - srl, same operands → 0x08000000.
  - sll, 1 by 0x25 (shamt 5) → 0x20.
  - sub, 0 − 1 → 0xFFFFFFFF.
- Priority and idle:
  - add_en, or_en and sub_en together with 0xF and 0x0 → 0xF (sub wins).
  - All enables low for a cycle → rd holds 0xF and rd_valid = 0.
- Word ops:
  - With ALU_WORD_OPS_EN defined, subw with 0xF and 0x1 → 0xE.
  - Without the macro, the same stimulus → rd_data holds and rd_valid = 0.
